router_fsm_nch: RTL and testbench

//  Parametrised packet-router control FSM for NUM_CH output channels (successor to the fixed 1x3 FSM).

---
 rtl/router_fsm_nch.sv | 110 +++++++++++
 tb/tb_router_fsm_nch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: NUM_CH-channel packet-router control FSM; define ROUTER_FSM_WAIT_TIMEOUT_EN to enable the wait-for-empty timeout
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              pkt_dropped,
  output logic [NUM_CH-1:0] addr_sel
);
  typedef enum logic [3:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, LOAD_PARITY,
    FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET
  } state_t;
  state_t state, next_state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_CH-1:0] din_sel;
  logic din_ok, din_empty, q_empty, q_srst, timeout;
  if (NUM_CH < 2 || NUM_CH > 16 || (1 << ADDR_W) < NUM_CH || WAIT_TIMEOUT < 1) begin : g_bad_param
    $error("router_fsm_nch: illegal parameter combination");
  end
  // Out-of-range addresses match no channel, so they read as not-empty and never soft-reset.
  always_comb begin
    din_ok = 1'b0;
    din_empty = 1'b0;
    din_sel = '0;
    q_empty = 1'b0;
    q_srst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_in == ADDR_W'(i)) begin
        din_ok = 1'b1;
        din_empty = fifo_empty[i];
        din_sel[i] = 1'b1;
      end
      if (addr_q == ADDR_W'(i)) begin
        q_empty = fifo_empty[i];
        q_srst = soft_reset[i];
      end
    end
  end
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  always_ff @(posedge clock) begin
    if (reset) wait_cnt <= '0;
    else wait_cnt <= (state == WAIT_TILL_EMPTY) ? wait_cnt + 1'b1 : '0;
  end
  assign timeout = wait_cnt == TW'(WAIT_TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:     if (pkt_valid) next_state = !din_ok ? DROP_PACKET : din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    next_state = LOAD_DATA;
      WAIT_TILL_EMPTY:    next_state = q_empty ? LOAD_FIRST_DATA : timeout ? DROP_PACKET : WAIT_TILL_EMPTY;
      LOAD_DATA:          next_state = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE:    if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    next_state = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:        if (!pkt_valid) next_state = DECODE_ADDRESS;
      default:            next_state = DECODE_ADDRESS;
    endcase
    state_d = (state != DECODE_ADDRESS && q_srst) ? DECODE_ADDRESS : next_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      addr_q <= '0;
      addr_sel <= '0;
      pkt_dropped <= 1'b0;
    end else begin
      state <= state_d;
      pkt_dropped <= state_d == DROP_PACKET && state != DROP_PACKET;
      if (state == DECODE_ADDRESS && pkt_valid) begin
        addr_q <= data_in;
        addr_sel <= din_sel;
      end
    end
  end
  assign detect_add    = state == DECODE_ADDRESS;
  assign lfd_state     = state == LOAD_FIRST_DATA;
  assign ld_state      = state == LOAD_DATA;
  assign laf_state     = state == LOAD_AFTER_FULL;
  assign full_state    = state == FIFO_FULL_STATE;
  assign rst_int_reg   = state == CHECK_PARITY_ERROR;
  assign drop_state    = state == DROP_PACKET;
  assign write_enb_reg = state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
  assign busy          = state inside {LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, FIFO_FULL_STATE,
                                       LOAD_AFTER_FULL, CHECK_PARITY_ERROR};
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed and random checks of router_fsm_nch against a behavioural model
`timescale 1ns/1ps
module tb_router_fsm_nch;
  localparam int NUM_CH = 3, ADDR_W = 2, WAIT_TIMEOUT = 8;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0, fifo_full = 1'b0;
  logic [ADDR_W-1:0] data_in = '0;
  logic [NUM_CH-1:0] fifo_empty = '1, soft_reset = '0, addr_sel;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, drop_state, pkt_dropped;
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;
  always #5 clock = ~clock;
  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .drop_state(drop_state),
    .pkt_dropped(pkt_dropped), .addr_sel(addr_sel));
  typedef enum {P_IDLE, P_FIRST, P_WAIT, P_DATA, P_PAR, P_FULL, P_AFTER, P_CHK, P_DROP} phase_t;
  phase_t ph = P_IDLE;
  int m_addr = 0, waited = 0;
  logic [NUM_CH-1:0] m_sel = '0;
  bit m_pulse = 1'b0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [NUM_CH-1:0] onehot(input int a);
    logic [NUM_CH-1:0] v;
    v = '0;
    if (a < NUM_CH) v[a] = 1'b1;
    return v;
  endfunction
  function automatic phase_t model_next();
    phase_t nx;
    nx = ph;
    case (ph)
      P_IDLE:  if (pkt_valid) nx = int'(data_in) >= NUM_CH ? P_DROP : fifo_empty[data_in] ? P_FIRST : P_WAIT;
      P_FIRST: nx = P_DATA;
      P_WAIT:  nx = fifo_empty[m_addr] ? P_FIRST : (TIMEOUT_ON && waited + 1 >= WAIT_TIMEOUT) ? P_DROP : P_WAIT;
      P_DATA:  nx = fifo_full ? P_FULL : !pkt_valid ? P_PAR : P_DATA;
      P_PAR:   nx = P_CHK;
      P_FULL:  nx = fifo_full ? P_FULL : P_AFTER;
      P_AFTER: nx = parity_done ? P_IDLE : low_pkt_valid ? P_PAR : P_DATA;
      P_CHK:   nx = fifo_full ? P_FULL : P_IDLE;
      P_DROP:  nx = pkt_valid ? P_DROP : P_IDLE;
      default: nx = P_IDLE;
    endcase
    if (ph != P_IDLE && m_addr < NUM_CH && soft_reset[m_addr]) nx = P_IDLE;
    return nx;
  endfunction
  function automatic logic [9:0] expect_outs(input phase_t p, input bit pulse);
    return {p inside {P_FIRST, P_WAIT, P_PAR, P_FULL, P_AFTER, P_CHK}, p == P_IDLE, p == P_FIRST, p == P_DATA,
            p == P_AFTER, p == P_FULL, p inside {P_DATA, P_PAR, P_AFTER}, p == P_CHK, p == P_DROP, pulse};
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      ph <= P_IDLE; m_addr <= 0; m_sel <= '0; waited <= 0; m_pulse <= 1'b0;
    end else begin
      ph <= model_next();
      m_pulse <= model_next() == P_DROP && ph != P_DROP;
      waited <= ph == P_WAIT ? waited + 1 : 0;
      if (ph == P_IDLE && pkt_valid) begin
        m_addr <= int'(data_in);
        m_sel <= onehot(int'(data_in));
      end
    end
  end
  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_outs", {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
                         rst_int_reg, drop_state, pkt_dropped}, expect_outs(ph, m_pulse));
      chk("model_addr_sel", addr_sel, m_sel);
    end
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  initial begin
    tick(); tick();
    chk_en = 1'b1;
    chk("t1_detect", detect_add, 1); chk("t1_busy", busy, 0);
    chk("t1_addr_sel", addr_sel, 0); chk("t1_we", write_enb_reg, 0);
    reset = 1'b0;
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111;
    tick();
    chk("t2_lfd", {lfd_state, busy}, 2'b11); chk("t2_addr_sel", addr_sel, 3'b100);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_ld", {ld_state, write_enb_reg, busy}, 3'b110);
      if (k == 3) pkt_valid = 1'b0;
      tick();
    end
    chk("t2_lp", {write_enb_reg, busy, ld_state}, 3'b110);
    tick();
    chk("t2_cpe", {rst_int_reg, busy}, 2'b11);
    tick();
    chk("t2_decode", detect_add, 1);
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); tick();
    chk("t3_ld", ld_state, 1);
    fifo_full = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t3_full", {full_state, busy, write_enb_reg}, 3'b110);
      if (k == 2) fifo_full = 1'b0;
      tick();
    end
    chk("t3_laf", {laf_state, busy, write_enb_reg}, 3'b111);
    tick();
    chk("t3_back_ld", ld_state, 1);
    pkt_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3_decode", detect_add, 1);
    pkt_valid = 1'b1; data_in = 2'd3;
    tick();
    chk("t4_drop_entry", {drop_state, pkt_dropped, write_enb_reg, busy}, 4'b1100);
    chk("t4_addr_sel", addr_sel, 0);
    tick();
    chk("t4_drop_hold", {drop_state, pkt_dropped, write_enb_reg, busy}, 4'b1000);
    tick();
    chk("t4_drop_hold2", {drop_state, pkt_dropped, write_enb_reg, busy}, 4'b1000);
    pkt_valid = 1'b0;
    tick();
    chk("t4_decode", {detect_add, pkt_dropped}, 2'b10);
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    tick();
    chk("t5_wait", {busy, detect_add, lfd_state}, 3'b100); chk("t5_addr_sel", addr_sel, 3'b010);
    pkt_valid = 1'b0; soft_reset = 3'b001;
    tick();
    chk("t5_other_srst", {busy, detect_add, lfd_state}, 3'b100);
    soft_reset = 3'b010;
    tick();
    chk("t5_own_srst", detect_add, 1);
    soft_reset = 3'b000;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    pkt_valid = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("t6_wait", {busy, drop_state}, 2'b10);
      tick();
    end
    chk("t6_timeout_drop", {drop_state, pkt_dropped}, 2'b11);
    pkt_valid = 1'b0;
    tick();
    pkt_valid = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) tick();
    chk("t6_last_wait", {busy, drop_state}, 2'b10);
    fifo_empty = 3'b111;
    tick();
    chk("t6_empty_wins", {lfd_state, drop_state}, 2'b10);
    pkt_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_decode", detect_add, 1);
`endif
    for (int n = 0; n < 4000; n++) begin
      reset = $urandom_range(0, 299) == 0;
      pkt_valid = $urandom_range(0, 3) != 0;
      data_in = ADDR_W'($urandom_range(0, 3));
      fifo_full = $urandom_range(0, 3) == 0;
      parity_done = $urandom_range(0, 3) == 0;
      low_pkt_valid = $urandom_range(0, 3) == 0;
      for (int i = 0; i < NUM_CH; i++) begin
        fifo_empty[i] = $urandom_range(0, 3) == 0;
        soft_reset[i] = $urandom_range(0, 49) == 0;
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
